// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared state encodings and default debounce lengths
package button_debouncer_pkg;
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;
  localparam int DEBOUNCE_CYCLES_SIM   = 10;
  localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic r_s1;
  logic r_s2;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  assign q = r_s2;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise, debounce and count presses of a raw button
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             clear_count,
  output logic             btn_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EVT_W-1:0] press_count
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_btn_out, w_out_nxt;
  logic             r_rise, w_rise;
  logic             r_fall, w_fall;
  logic [EVT_W-1:0] r_press;
  logic             w_btn_sync;
  logic             w_last;
  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (w_btn_sync)
  );
  assign w_last = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // next-state logic: a new level must hold DEBOUNCE_CYCLES edges in a WAIT state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_btn_out;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      S_LOW:
        if (w_btn_sync) begin
          w_state_nxt = S_WAIT_H;
          w_cnt_nxt   = '0;
        end
      S_WAIT_H:
        if (!w_btn_sync) w_state_nxt = S_LOW;
        else if (w_last) begin
          w_state_nxt = S_HIGH;
          w_out_nxt   = 1'b1;
          w_rise      = 1'b1;
        end else w_cnt_nxt = r_cnt + 1'b1;
      S_HIGH:
        if (!w_btn_sync) begin
          w_state_nxt = S_WAIT_L;
          w_cnt_nxt   = '0;
        end
      S_WAIT_L:
        if (w_btn_sync) w_state_nxt = S_HIGH;
        else if (w_last) begin
          w_state_nxt = S_LOW;
          w_out_nxt   = 1'b0;
          w_fall      = 1'b1;
        end else w_cnt_nxt = r_cnt + 1'b1;
    endcase
  end
  // FSM state, counter and registered outputs; pulses come from the same edge as btn_out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_btn_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_btn_out <= w_out_nxt;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
    end
  // press counter wraps naturally; a clear wins over a simultaneous rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_press <= '0;
    else r_press <= clear_count ? '0 : w_rise ? r_press + 1'b1 : r_press;
  assign btn_out     = r_btn_out;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign press_count = r_press;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench, expected pulse events queued by stimulus and checked by a monitor
`timescale 1ns/100ps
module tb_button_debouncer;
  typedef struct {
    bit         rise;
    int         cyc;
    logic [7:0] cnt;
  } ev_t;
  logic       clk = 0;
  logic       rst_n;
  logic       btn_in;
  logic       clear_count;
  logic       btn_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] press_count;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  ev_t        q[$];
  button_debouncer #(.DEBOUNCE_CYCLES(10), .EVT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .clear_count(clear_count),
    .btn_out    (btn_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .press_count(press_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic push(bit r, int c, logic [7:0] n);
    ev_t e;
    e.rise = r;
    e.cyc  = c;
    e.cnt  = n;
    q.push_back(e);
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n === 1'b1 && (rise_pulse === 1'b1 || fall_pulse === 1'b1)) begin
      chk("both_pulses", {31'b0, rise_pulse & fall_pulse}, 0);
      if (q.size() == 0) chk("unexpected_pulse", {31'b0, rise_pulse}, {31'b0, ~rise_pulse});
      else begin
        ev_t e;
        e = q.pop_front();
        chk(e.rise ? "rise_kind" : "fall_kind", {31'b0, rise_pulse}, {31'b0, e.rise});
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_btn_out", {31'b0, btn_out}, {31'b0, e.rise});
        chk("pulse_count", {24'b0, press_count}, {24'b0, e.cnt});
      end
    end
  initial begin
    logic [7:0] n;
    rst_n = 0;
    btn_in = 1;
    clear_count = 0;
    #10;
    chk("rst_btn_out", {31'b0, btn_out}, 0);
    chk("rst_rise", {31'b0, rise_pulse}, 0);
    chk("rst_fall", {31'b0, fall_pulse}, 0);
    chk("rst_count", {24'b0, press_count}, 0);
    #10;
    rst_n = 1;
    push(1, cyc + 13, 8'd1);
    tick(20);
    btn_in = 0;
    push(0, cyc + 13, 8'd1);
    tick(20);
    btn_in = 1;
    push(1, cyc + 13, 8'd2);
    tick(50);
    chk("clean_press_level", {31'b0, btn_out}, 1);
    btn_in = 0;
    push(0, cyc + 13, 8'd2);
    tick(20);
    for (int i = 0; i < 6; i++) begin
      btn_in = ~btn_in;
      tick(3);
      chk("bounce_no_change", {31'b0, btn_out}, 0);
    end
    btn_in = 1;
    push(1, cyc + 13, 8'd3);
    tick(30);
    btn_in = 0;
    tick(5);
    btn_in = 1;
    tick(30);
    chk("glitch_hold_high", {31'b0, btn_out}, 1);
    btn_in = 0;
    push(0, cyc + 13, 8'd3);
    tick(30);
    chk("long_low_level", {31'b0, btn_out}, 0);
    for (int k = 4; k <= 256; k++) begin
      n = 8'(k);
      btn_in = 1;
      push(1, cyc + 13, n);
      tick(16);
      btn_in = 0;
      push(0, cyc + 13, n);
      tick(16);
    end
    chk("wrap_count", {24'b0, press_count}, 0);
    clear_count = 1;
    tick(1);
    clear_count = 0;
    chk("clear_idle", {24'b0, press_count}, 0);
    btn_in = 1;
    push(1, cyc + 13, 8'd0);
    tick(12);
    clear_count = 1;
    tick(1);
    clear_count = 0;
    tick(5);
    btn_in = 0;
    push(0, cyc + 13, 8'd0);
    tick(20);
    btn_in = 1;
    push(1, cyc + 13, 8'd1);
    tick(20);
    btn_in = 0;
    push(0, cyc + 13, 8'd1);
    tick(20);
    btn_in = 1;
    tick(8);
    chk("midq_cnt_before", {30'b0, dut.r_cnt}, 5);
    rst_n = 0;
    #1;
    chk("midq_btn_out", {31'b0, btn_out}, 0);
    chk("midq_count", {24'b0, press_count}, 0);
    chk("midq_cnt", {30'b0, dut.r_cnt}, 0);
    chk("midq_state", {30'b0, dut.r_state}, 0);
    btn_in = 0;
    tick(2);
    rst_n = 1;
    tick(30);
    chk("post_rst_state", {30'b0, dut.r_state}, 0);
    chk("post_rst_out", {31'b0, btn_out}, 0);
    btn_in = 1;
    push(1, cyc + 13, 8'd1);
    tick(20);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
